// File: rtl/expo_sched.sv
// rtl/expo_sched.sv - round-robin scheduler sharing one expo_calc between NCH voices
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   req         per-voice conversion request (level)
//   cv_flat     voice i CV in bits [12i+11:12i]
//   range_flat  voice i range select in bits [2i+1:2i]
//   ack         one-cycle grant pulse, CV/range latched
//   expo_in     CV to expo_calc
//   expo_in_v   input-valid to expo_calc
//   expo_range  range to expo_calc, held from issue to capture
//   expo_out    expo_calc result
//   freq_flat   voice i frequency word in bits [32i+31:32i]
//   freq_v      one-cycle strobe, freq for voice i updated
//   busy        high in every state except IDLE

module expo_sched #(
    parameter int NCH = 4,
    parameter int LAT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*12-1:0] cv_flat,
    input  logic [NCH*2-1:0]  range_flat,
    output logic [NCH-1:0]    ack,
    output logic [11:0]       expo_in,
    output logic              expo_in_v,
    output logic [1:0]        expo_range,
    input  logic [31:0]       expo_out,
    output logic [NCH*32-1:0] freq_flat,
    output logic [NCH-1:0]    freq_v,
    output logic              busy
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [GW-1:0]           rr_q;
    logic [GW-1:0]           gnt_q;
    logic [CW-1:0]           cnt_q;
    logic [NCH-1:0]          ack_q;
    logic [11:0]             expo_in_q;
    logic                    expo_in_v_q;
    logic [1:0]              expo_range_q;
    logic [NCH-1:0][31:0]    freq_q;
    logic [NCH-1:0]          freq_v_q;
    logic                    busy_q;

    logic                    found_d;
    logic [GW-1:0]           gnt_d;
    int                      cand;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found_d = 1'b0;
        gnt_d   = '0;
        cand    = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = (int'(rr_q) + k) % NCH;
            if (!found_d && req[GW'(cand)]) begin
                found_d = 1'b1;
                gnt_d   = GW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_q         <= GW'(NCH - 1);
            gnt_q        <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            expo_in_q    <= '0;
            expo_in_v_q  <= 1'b0;
            expo_range_q <= '0;
            freq_q       <= '0;
            freq_v_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    freq_v_q <= '0;
                    if (found_d) begin
                        expo_in_q    <= cv_flat[int'(gnt_d)*12 +: 12];
                        expo_range_q <= range_flat[int'(gnt_d)*2 +: 2];
                        expo_in_v_q  <= 1'b1;
                        ack_q        <= NCH'(1) << gnt_d;
                        rr_q         <= gnt_d;
                        gnt_q        <= gnt_d;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    expo_in_v_q <= 1'b0;
                    ack_q       <= '0;
                    cnt_q       <= CW'(LAT - 1);
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // expo_in/expo_range stay untouched: expo_calc applies
                    // range at its final stage.
                    if (cnt_q == '0) begin
                        freq_q[gnt_q] <= expo_out;
                        freq_v_q      <= NCH'(1) << gnt_q;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign expo_in    = expo_in_q;
    assign expo_in_v  = expo_in_v_q;
    assign expo_range = expo_range_q;
    assign freq_flat  = freq_q;
    assign freq_v     = freq_v_q;
    assign busy       = busy_q;

endmodule
